// File: rtl/pim_block_buffer.sv
// Block memory for the scan core: loads one block from a stream, serves
// combinational reads and notation write-back, then drains the annotated block.
module pim_block_buffer #(
    parameter int BLOCK_SIZE   = 30,
    parameter int SIGNAL_WIDTH = 18,
    parameter int DIST_WIDTH   = 14,
    parameter int PEAK_NUM     = 4,
    parameter int NOT_WIDTH    = 2 * PEAK_NUM,
    parameter int DATA_WIDTH   = (SIGNAL_WIDTH + DIST_WIDTH) * PEAK_NUM,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DIST_WIDTH-1:0] in_dist,
    output logic                  block_ready,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic                  core_wr_en,
    input  logic [NOT_WIDTH-1:0]  core_not_wr,
    output logic [DATA_WIDTH-1:0] core_mem_data,
    output logic [DIST_WIDTH-1:0] core_distance,
    output logic [NOT_WIDTH-1:0]  core_not_rd,
    input  logic                  drain_start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DIST_WIDTH-1:0] out_dist,
    output logic [NOT_WIDTH-1:0]  out_not,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(BLOCK_SIZE - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q [BLOCK_SIZE];
    logic [DATA_WIDTH-1:0]   data_d [BLOCK_SIZE];
    logic [DIST_WIDTH-1:0]   dist_q [BLOCK_SIZE];
    logic [DIST_WIDTH-1:0]   dist_d [BLOCK_SIZE];
    logic [NOT_WIDTH-1:0]    not_q  [BLOCK_SIZE];
    logic [NOT_WIDTH-1:0]    not_d  [BLOCK_SIZE];
    logic                    addr_ok;

    assign addr_ok = (core_addr <= LAST);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        dist_d        = dist_q;
        not_d         = not_q;
        in_ready      = 1'b0;
        block_ready   = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        out_data      = '0;
        out_dist      = '0;
        out_not       = '0;
        core_mem_data = '0;
        core_distance = '0;
        core_not_rd   = '0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d[cnt_q] = in_data;
                    dist_d[cnt_q] = in_dist;
                    not_d[cnt_q]  = '0;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = SERVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SERVE: begin
                block_ready = 1'b1;
                // Out-of-range addresses read as zero and never write
                if (addr_ok) begin
                    core_mem_data = data_q[core_addr];
                    core_distance = dist_q[core_addr];
                    core_not_rd   = not_q[core_addr];
                    if (core_wr_en) begin
                        not_d[core_addr] = core_not_wr;
                    end
                end
                if (drain_start) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = data_q[cnt_q];
                out_dist  = dist_q[cnt_q];
                out_not   = not_q[cnt_q];
                out_last  = (cnt_q == LAST);
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        dist_q <= dist_d;
        not_q  <= not_d;
    end

endmodule

// File: tb/tb_pim_block_buffer.sv
// Randomized bench for pim_block_buffer against a block-level array model.
module tb_pim_block_buffer;

    localparam int BS = 30;
    localparam int DW = 128;
    localparam int TW = 14;
    localparam int NW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [TW-1:0] in_dist = '0;
    logic          block_ready;
    logic [AW-1:0] core_addr = '0;
    logic          core_wr_en = 1'b0;
    logic [NW-1:0] core_not_wr = '0;
    logic [DW-1:0] core_mem_data;
    logic [TW-1:0] core_distance;
    logic [NW-1:0] core_not_rd;
    logic          drain_start = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_dist;
    logic [NW-1:0] out_not;
    logic          out_last;

    pim_block_buffer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dist(in_dist),
        .block_ready(block_ready),
        .core_addr(core_addr), .core_wr_en(core_wr_en),
        .core_not_wr(core_not_wr),
        .core_mem_data(core_mem_data),
        .core_distance(core_distance),
        .core_not_rd(core_not_rd),
        .drain_start(drain_start),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dist(out_dist),
        .out_not(out_not), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected block contents
    logic [DW-1:0] m_data [BS];
    logic [TW-1:0] m_dist [BS];
    logic [NW-1:0] m_not  [BS];

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        core_wr_en = 1'b0;
        drain_start = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_blk_ready", block_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_block(input bit seq, input bit poke);
        for (int i = 0; i < BS; i++) begin
            if (!seq && $urandom_range(3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                core_wr_en = poke;
                core_addr = AW'($urandom);
                core_not_wr = NW'($urandom);
                #1;
                chk("load_gap_rdy", in_ready, 1);
            end
            @(negedge clk);
            m_data[i] = seq ? DW'(i) : rnd128();
            m_dist[i] = seq ? TW'(100 + i) : TW'($urandom);
            m_not[i]  = '0;
            in_valid = 1'b1;
            in_data = m_data[i];
            in_dist = m_dist[i];
            core_wr_en = poke;
            core_addr = AW'($urandom);
            core_not_wr = NW'($urandom);
            #1;
            chk("load_rdy", in_ready, 1);
            chk("load_blk", block_ready, 0);
            chk("load_core_rd", core_mem_data, 0);
        end
        @(negedge clk);
        in_data = rnd128();
        core_wr_en = 1'b0;
        #1;
        chk("load_done_rdy", in_ready, 0);
        chk("load_done_blk", block_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        @(negedge clk);
        core_addr = a;
        core_wr_en = 1'b0;
        #1;
        if (int'(a) < BS) begin
            chk("rd_data", core_mem_data, m_data[a]);
            chk("rd_dist", core_distance, m_dist[a]);
            chk("rd_not", core_not_rd, m_not[a]);
        end else begin
            chk("rd_oor_data", core_mem_data, 0);
            chk("rd_oor_not", core_not_rd, 0);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NW-1:0] v);
        @(negedge clk);
        core_addr = a;
        core_wr_en = 1'b1;
        core_not_wr = v;
        #1;
        if (int'(a) < BS) begin
            chk("wr_old_not", core_not_rd, m_not[a]);
            m_not[a] = v;
        end else begin
            chk("wr_oor_not", core_not_rd, 0);
        end
    endtask

    task automatic serve_random(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(1) == 1)
                wr(AW'($urandom), NW'($urandom));
            else
                rd(AW'($urandom));
        end
    endtask

    task automatic drain(input bit rnd, input int stop_at);
        int idx;
        int cyc;
        logic [AW-1:0] a;
        @(negedge clk);
        a = AW'($urandom);
        drain_start = 1'b1;
        core_addr = a;
        core_wr_en = 1'b1;
        core_not_wr = NW'($urandom);
        #1;
        chk("drn_start_blk", block_ready, 1);
        if (int'(a) < BS) m_not[a] = core_not_wr;
        idx = 0;
        cyc = 0;
        while (idx < BS && idx != stop_at && cyc < 200) begin
            @(negedge clk);
            drain_start = $urandom_range(1) == 1;
            core_wr_en = $urandom_range(1) == 1;
            core_addr = AW'($urandom);
            core_not_wr = NW'($urandom);
            out_ready = rnd ? ($urandom_range(1) == 1) : (cyc % 2 == 0);
            #1;
            chk("drn_valid", out_valid, 1);
            chk("drn_data", out_data, m_data[idx]);
            chk("drn_dist", out_dist, m_dist[idx]);
            chk("drn_not", out_not, m_not[idx]);
            chk("drn_last", out_last, idx == BS - 1);
            chk("drn_core_zero", core_not_rd, 0);
            if (out_ready) idx++;
            cyc++;
        end
        if (cyc >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drn_timeout got=%0d beats exp=%0d", idx, BS);
        end
        drain_start = 1'b0;
        if (stop_at < 0) begin
            @(negedge clk);
            out_ready = 1'b0;
            core_wr_en = 1'b0;
            #1;
            chk("drn_end_valid", out_valid, 0);
            chk("drn_end_rdy", in_ready, 1);
            chk("drn_end_blk", block_ready, 0);
        end
    endtask

    initial begin
        #1;
        chk("por_in_ready", in_ready, 1);
        chk("por_blk_ready", block_ready, 0);
        chk("por_out_valid", out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed first block: data=i, dist=100+i
        load_block(1'b1, 1'b0);
        rd(5'd7);
        chk("addr7_data", core_mem_data, 7);
        chk("addr7_dist", core_distance, 107);
        wr(5'd3, 8'hA5);
        chk("wr3_same_cycle", core_not_rd, 0);
        rd(5'd3);
        chk("rd3_after_wr", core_not_rd, 8'hA5);
        wr(5'd31, 8'h5A);
        rd(5'd31);
        serve_random(6);
        drain(1'b0, -1);

        // Reset partway through a load
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = rnd128();
        end
        do_reset();
        load_block(1'b0, 1'b1);
        serve_random(10);

        // Reset partway through a drain
        drain(1'b1, 5);
        do_reset();
        load_block(1'b0, 1'b0);
        serve_random(10);
        drain(1'b1, -1);

        // Back-to-back block with new data
        load_block(1'b0, 1'b1);
        serve_random(12);
        drain(1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
